axi4lite_sram_slave: RTL and testbench

Parametrised AXI4-Lite slave fronting an on-chip single-read/single-write synchronous SRAM; it is the generic replacement for fixed 64-bit external-memory wrappers. Data width, depth and base address are parameters. Write address and write data are accepted independently and in either order. Backpressure on B and R is honoured, responses are held stable until accepted, and an optional address-range check returns SLVERR.

---
 rtl/axi4lite_pkg.sv | 21 ++
 rtl/sram_1r1w.sv | 40 ++++
 rtl/axi4lite_sram_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi4lite_sram_slave.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite constants and FSM state types for the SRAM slave.
package axi4lite_pkg;

  localparam int AXI_RESP_BITS = 2;
  localparam int AXI_PROT_BITS = 3;

  localparam logic [AXI_RESP_BITS-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_BITS-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_READ = 2'b01,
    R_RESP = 2'b10
  } rd_state_t;

endpackage

// File: rtl/sram_1r1w.sv
// Behavioural single-read/single-write SRAM: registered read port, byte-enabled write port.
module sram_1r1w #(
  parameter int DATA_BITS = 64,
  parameter int MEM_WORDS = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_en,
  input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
  output logic [DATA_BITS-1:0]         rd_data,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_idx,
  input  logic [DATA_BITS-1:0]         wr_data,
  input  logic [DATA_BITS/8-1:0]       wr_strb
);
  localparam int STRB_BITS = DATA_BITS / 8;

  logic [DATA_BITS-1:0] mem_r [MEM_WORDS];

  // byte-enabled write; array contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // read-first output register: a same-cycle write is not visible here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= {DATA_BITS{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_idx];
    end
  end

endmodule

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave fronting a 1R1W synchronous SRAM with independent read/write channels.
// Define AXI4LITE_SRAM_RANGE_CHK_EN to return SLVERR outside [BASE_ADDR, BASE_ADDR+window).
module axi4lite_sram_slave
  import axi4lite_pkg::*;
#(
  parameter int          DATA_BITS = 64,
  parameter int          ADDR_BITS = 32,
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     s_axi4lite_aw_ready,
  input  logic                     s_axi4lite_aw_valid,
  input  logic [ADDR_BITS-1:0]     s_axi4lite_aw_addr,
  input  logic [AXI_PROT_BITS-1:0] s_axi4lite_aw_prot,
  output logic                     s_axi4lite_w_ready,
  input  logic                     s_axi4lite_w_valid,
  input  logic [DATA_BITS-1:0]     s_axi4lite_w_data,
  input  logic [DATA_BITS/8-1:0]   s_axi4lite_w_strb,
  input  logic                     s_axi4lite_b_ready,
  output logic                     s_axi4lite_b_valid,
  output logic [AXI_RESP_BITS-1:0] s_axi4lite_b_resp,
  output logic                     s_axi4lite_ar_ready,
  input  logic                     s_axi4lite_ar_valid,
  input  logic [ADDR_BITS-1:0]     s_axi4lite_ar_addr,
  input  logic [AXI_PROT_BITS-1:0] s_axi4lite_ar_prot,
  input  logic                     s_axi4lite_r_ready,
  output logic                     s_axi4lite_r_valid,
  output logic [DATA_BITS-1:0]     s_axi4lite_r_data,
  output logic [AXI_RESP_BITS-1:0] s_axi4lite_r_resp
);
  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int OFF_BITS  = $clog2(STRB_BITS);
  localparam int IDX_BITS  = $clog2(MEM_WORDS);

  logic                     run_r;
  wr_state_t                wr_state_r;
  logic                     aw_held_r;
  logic                     w_held_r;
  logic [ADDR_BITS-1:0]     aw_addr_r;
  logic [DATA_BITS-1:0]     w_data_r;
  logic [STRB_BITS-1:0]     w_strb_r;
  logic [AXI_RESP_BITS-1:0] b_resp_r;
  rd_state_t                rd_state_r;
  logic [ADDR_BITS-1:0]     ar_addr_r;
  logic [AXI_RESP_BITS-1:0] r_resp_r;
  logic [DATA_BITS-1:0]     sram_rd_data_s;
  logic aw_fire_s, w_fire_s, ar_fire_s;
  logic write_en_s, read_en_s, wr_ok_s, rd_ok_s;
  logic unused_bits_s;

`ifdef AXI4LITE_SRAM_RANGE_CHK_EN
  function automatic logic in_window(input logic [ADDR_BITS-1:0] addr);
    logic [63:0] addr_w;
    addr_w = 64'(addr);
    return (addr_w >= BASE_ADDR) && (addr_w < BASE_ADDR + 64'(MEM_WORDS * STRB_BITS));
  endfunction

  assign wr_ok_s = in_window(aw_addr_r);
  assign rd_ok_s = in_window(ar_addr_r);
`else
  assign wr_ok_s = 1'b1;
  assign rd_ok_s = 1'b1;
`endif

  // run_r keeps every ready low while reset is held
  assign s_axi4lite_aw_ready = run_r & (wr_state_r == W_COLLECT) & ~aw_held_r;
  assign s_axi4lite_w_ready  = run_r & (wr_state_r == W_COLLECT) & ~w_held_r;
  assign s_axi4lite_b_valid  = (wr_state_r == W_RESP);
  assign s_axi4lite_b_resp   = b_resp_r;
  assign s_axi4lite_ar_ready = run_r & (rd_state_r == R_IDLE);
  assign s_axi4lite_r_valid  = (rd_state_r == R_RESP);
  assign s_axi4lite_r_resp   = r_resp_r;
  assign s_axi4lite_r_data   = (r_resp_r == RESP_OKAY) ? sram_rd_data_s : {DATA_BITS{1'b0}};

  assign aw_fire_s  = s_axi4lite_aw_valid & s_axi4lite_aw_ready;
  assign w_fire_s   = s_axi4lite_w_valid & s_axi4lite_w_ready;
  assign ar_fire_s  = s_axi4lite_ar_valid & s_axi4lite_ar_ready;
  assign write_en_s = (wr_state_r == W_COLLECT) & aw_held_r & w_held_r;
  assign read_en_s  = (rd_state_r == R_READ) & rd_ok_s;

  assign unused_bits_s = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot, aw_addr_r, ar_addr_r};

  // leaves the reset-held state one edge after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // write channel: collect AW and W in any order, write, then hold B until accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_r <= W_COLLECT;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_addr_r  <= {ADDR_BITS{1'b0}};
      w_data_r   <= {DATA_BITS{1'b0}};
      w_strb_r   <= {STRB_BITS{1'b0}};
      b_resp_r   <= RESP_OKAY;
    end else begin
      case (wr_state_r)
        W_COLLECT: begin
          if (aw_fire_s) begin
            aw_addr_r <= s_axi4lite_aw_addr;
            aw_held_r <= 1'b1;
          end
          if (w_fire_s) begin
            w_data_r <= s_axi4lite_w_data;
            w_strb_r <= s_axi4lite_w_strb;
            w_held_r <= 1'b1;
          end
          if (write_en_s) begin
            b_resp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            wr_state_r <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi4lite_b_ready) begin
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            wr_state_r <= W_COLLECT;
          end
        end
        default: begin
          aw_held_r  <= 1'b0;
          w_held_r   <= 1'b0;
          wr_state_r <= W_COLLECT;
        end
      endcase
    end
  end

  // read channel: capture AR, one SRAM read cycle, then hold R until accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_r <= R_IDLE;
      ar_addr_r  <= {ADDR_BITS{1'b0}};
      r_resp_r   <= RESP_OKAY;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (ar_fire_s) begin
            ar_addr_r  <= s_axi4lite_ar_addr;
            rd_state_r <= R_READ;
          end
        end
        R_READ: begin
          r_resp_r   <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
          rd_state_r <= R_RESP;
        end
        R_RESP: begin
          if (s_axi4lite_r_ready) begin
            rd_state_r <= R_IDLE;
          end
        end
        default: begin
          rd_state_r <= R_IDLE;
        end
      endcase
    end
  end

  sram_1r1w #(
    .DATA_BITS (DATA_BITS),
    .MEM_WORDS (MEM_WORDS)
  ) u_sram (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (read_en_s),
    .rd_idx  (ar_addr_r[IDX_BITS+OFF_BITS-1:OFF_BITS]),
    .rd_data (sram_rd_data_s),
    .wr_en   (write_en_s & wr_ok_s),
    .wr_idx  (aw_addr_r[IDX_BITS+OFF_BITS-1:OFF_BITS]),
    .wr_data (w_data_r),
    .wr_strb (w_strb_r)
  );

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Randomized scoreboard bench for axi4lite_sram_slave (64-bit data, 16 words, base 0x1000).
module tb_axi4lite_sram_slave;

  localparam int          DW   = 64;
  localparam int          AW   = 32;
  localparam int          WORDS = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] WIN  = 32'h0000_0080;

  logic          clk;
  logic          reset;
  logic          s_axi4lite_aw_ready, s_axi4lite_aw_valid;
  logic [AW-1:0] s_axi4lite_aw_addr;
  logic [2:0]    s_axi4lite_aw_prot;
  logic          s_axi4lite_w_ready, s_axi4lite_w_valid;
  logic [DW-1:0] s_axi4lite_w_data;
  logic [7:0]    s_axi4lite_w_strb;
  logic          s_axi4lite_b_ready, s_axi4lite_b_valid;
  logic [1:0]    s_axi4lite_b_resp;
  logic          s_axi4lite_ar_ready, s_axi4lite_ar_valid;
  logic [AW-1:0] s_axi4lite_ar_addr;
  logic [2:0]    s_axi4lite_ar_prot;
  logic          s_axi4lite_r_ready, s_axi4lite_r_valid;
  logic [DW-1:0] s_axi4lite_r_data;
  logic [1:0]    s_axi4lite_r_resp;

  axi4lite_sram_slave #(
    .DATA_BITS (DW),
    .ADDR_BITS (AW),
    .MEM_WORDS (WORDS),
    .BASE_ADDR (64'h0000_0000_0000_1000)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .s_axi4lite_aw_ready (s_axi4lite_aw_ready),
    .s_axi4lite_aw_valid (s_axi4lite_aw_valid),
    .s_axi4lite_aw_addr  (s_axi4lite_aw_addr),
    .s_axi4lite_aw_prot  (s_axi4lite_aw_prot),
    .s_axi4lite_w_ready  (s_axi4lite_w_ready),
    .s_axi4lite_w_valid  (s_axi4lite_w_valid),
    .s_axi4lite_w_data   (s_axi4lite_w_data),
    .s_axi4lite_w_strb   (s_axi4lite_w_strb),
    .s_axi4lite_b_ready  (s_axi4lite_b_ready),
    .s_axi4lite_b_valid  (s_axi4lite_b_valid),
    .s_axi4lite_b_resp   (s_axi4lite_b_resp),
    .s_axi4lite_ar_ready (s_axi4lite_ar_ready),
    .s_axi4lite_ar_valid (s_axi4lite_ar_valid),
    .s_axi4lite_ar_addr  (s_axi4lite_ar_addr),
    .s_axi4lite_ar_prot  (s_axi4lite_ar_prot),
    .s_axi4lite_r_ready  (s_axi4lite_r_ready),
    .s_axi4lite_r_valid  (s_axi4lite_r_valid),
    .s_axi4lite_r_data   (s_axi4lite_r_data),
    .s_axi4lite_r_resp   (s_axi4lite_r_resp)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0]  exp_b[$];
  rexp_t       exp_r[$];
  logic [63:0] mem_m [WORDS];
  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int last_aw_cyc = 0;
  int last_w_cyc = 0;
  int last_ar_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // reference model: address window, aliasing and byte merging by plain arithmetic
  function automatic bit in_win(input logic [31:0] a);
`ifdef AXI4LITE_SRAM_RANGE_CHK_EN
    return (a >= BASE) && (a < BASE + WIN);
`else
    return (a == a);
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd8) % 32'd16);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    if (in_win(a)) begin
      for (int b = 0; b < 8; b++) begin
        if (s[b]) mem_m[word_of(a)][b*8 +: 8] = d[b*8 +: 8];
      end
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic model_read(input logic [31:0] a);
    rexp_t e;
    if (in_win(a)) begin
      e.data = mem_m[word_of(a)];
      e.resp = 2'b00;
    end else begin
      e.data = 64'd0;
      e.resp = 2'b10;
    end
    exp_r.push_back(e);
  endtask

  // monitor: every presented response must match the queue head, popped on handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (s_axi4lite_b_valid) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got b_valid 1 required 0");
        end else begin
          chk("b_resp", 64'(s_axi4lite_b_resp), 64'(exp_b[0]));
          if (s_axi4lite_b_ready) void'(exp_b.pop_front());
        end
      end
      if (s_axi4lite_r_valid) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got r_valid 1 required 0");
        end else begin
          chk("r_data", s_axi4lite_r_data, exp_r[0].data);
          chk("r_resp", 64'(s_axi4lite_r_resp), 64'(exp_r[0].resp));
          if (s_axi4lite_r_ready) void'(exp_r.pop_front());
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    int n;
    s_axi4lite_aw_addr = a;
    s_axi4lite_aw_prot = 3'($urandom);
    s_axi4lite_aw_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi4lite_aw_ready && n < 50) begin n++; @(negedge clk); end
    if (!s_axi4lite_aw_ready) begin checks++; errors++; $display("FAIL aw_timeout: got no aw_ready required aw_ready"); end
    else last_aw_cyc = edge_cnt;
    @(posedge clk); #1;
    s_axi4lite_aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    int n;
    s_axi4lite_w_data = d;
    s_axi4lite_w_strb = s;
    s_axi4lite_w_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi4lite_w_ready && n < 50) begin n++; @(negedge clk); end
    if (!s_axi4lite_w_ready) begin checks++; errors++; $display("FAIL w_timeout: got no w_ready required w_ready"); end
    else last_w_cyc = edge_cnt;
    @(posedge clk); #1;
    s_axi4lite_w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n;
    s_axi4lite_ar_addr = a;
    s_axi4lite_ar_prot = 3'($urandom);
    s_axi4lite_ar_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi4lite_ar_ready && n < 50) begin n++; @(negedge clk); end
    if (!s_axi4lite_ar_ready) begin checks++; errors++; $display("FAIL ar_timeout: got no ar_ready required ar_ready"); end
    else last_ar_cyc = edge_cnt;
    @(posedge clk); #1;
    s_axi4lite_ar_valid = 1'b0;
  endtask

  // lead > 0: W issued that many cycles before AW; lead < 0: AW first
  task automatic wr_fire(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input int lead);
    fork
      begin
        if (lead < 0) begin repeat (-lead) @(posedge clk); #1; end
        send_w(d, s);
      end
      begin
        if (lead > 0) begin repeat (lead) @(posedge clk); #1; end
        send_aw(a);
      end
    join
  endtask

  task automatic wait_b_rise(output int c);
    c = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (s_axi4lite_b_valid) begin c = edge_cnt; break; end
    end
    if (c < 0) begin checks++; errors++; $display("FAIL b_timeout: got no b_valid required b_valid"); end
    @(posedge clk); #1;
  endtask

  task automatic wait_r_rise(output int c);
    c = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (s_axi4lite_r_valid) begin c = edge_cnt; break; end
    end
    if (c < 0) begin checks++; errors++; $display("FAIL r_timeout: got no r_valid required r_valid"); end
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((exp_b.size() > 0 || exp_r.size() > 0) && n < 100) begin
      s_axi4lite_b_ready = rnd ? 1'($urandom) : 1'b1;
      s_axi4lite_r_ready = rnd ? 1'($urandom) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (exp_b.size() > 0 || exp_r.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending required 0/0", exp_b.size(), exp_r.size());
      exp_b.delete(); exp_r.delete();
    end
    s_axi4lite_b_ready = 1'b1;
    s_axi4lite_r_ready = 1'b1;
  endtask

  task automatic full_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int lead, input bit rnd);
    int c;
    model_write(a, d, s);
    s_axi4lite_b_ready = !rnd;
    wr_fire(a, d, s, lead);
    wait_b_rise(c);
    chk("b_latency", 64'(c), 64'(((last_aw_cyc > last_w_cyc) ? last_aw_cyc : last_w_cyc) + 2));
    drain(rnd);
  endtask

  task automatic full_read(input logic [31:0] a, input bit rnd);
    int c;
    model_read(a);
    s_axi4lite_r_ready = !rnd;
    send_ar(a);
    wait_r_rise(c);
    chk("r_latency", 64'(c), 64'(last_ar_cyc + 2));
    drain(rnd);
  endtask

  // read whose expected data is a literal value rather than the model's
  task automatic const_read(input logic [31:0] a, input logic [63:0] d);
    rexp_t e;
    int c;
    e.data = d;
    e.resp = 2'b00;
    exp_r.push_back(e);
    send_ar(a);
    wait_r_rise(c);
    chk("r_latency", 64'(c), 64'(last_ar_cyc + 2));
    drain(1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_aw_ready"}, 64'(s_axi4lite_aw_ready), 64'd0);
    chk({tag, "_w_ready"},  64'(s_axi4lite_w_ready),  64'd0);
    chk({tag, "_ar_ready"}, 64'(s_axi4lite_ar_ready), 64'd0);
    chk({tag, "_b_valid"},  64'(s_axi4lite_b_valid),  64'd0);
    chk({tag, "_r_valid"},  64'(s_axi4lite_r_valid),  64'd0);
    chk({tag, "_b_resp"},   64'(s_axi4lite_b_resp),   64'd0);
    chk({tag, "_r_resp"},   64'(s_axi4lite_r_resp),   64'd0);
    chk({tag, "_r_data"},   s_axi4lite_r_data,        64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [63:0] d;
    reset = 1'b1;
    s_axi4lite_aw_valid = 1'b0; s_axi4lite_aw_addr = 32'd0; s_axi4lite_aw_prot = 3'd0;
    s_axi4lite_w_valid = 1'b0;  s_axi4lite_w_data = 64'd0;  s_axi4lite_w_strb = 8'd0;
    s_axi4lite_ar_valid = 1'b0; s_axi4lite_ar_addr = 32'd0; s_axi4lite_ar_prot = 3'd0;
    s_axi4lite_b_ready = 1'b1;  s_axi4lite_r_ready = 1'b1;

    @(posedge clk); @(negedge clk);
    chk_idle_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_aw_ready", 64'(s_axi4lite_aw_ready), 64'd1);
    chk("post_rst_w_ready",  64'(s_axi4lite_w_ready),  64'd1);
    chk("post_rst_ar_ready", 64'(s_axi4lite_ar_ready), 64'd1);
    @(posedge clk); #1;

    // give every word a known value
    for (int w = 0; w < WORDS; w++) full_write(BASE + 32'(w * 8), {$urandom, $urandom}, 8'hFF, 0, 1'b0);

    full_write(BASE + 32'h08, 64'h1122_3344_5566_7788, 8'hFF, 0, 1'b0);
    const_read(BASE + 32'h08, 64'h1122_3344_5566_7788);

    full_write(BASE + 32'h08, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 3, 1'b0);
    const_read(BASE + 32'h08, 64'h1122_3344_BBBB_BBBB);

    full_write(BASE + 32'h18, 64'h0123_4567_89AB_CDEF, 8'h00, -2, 1'b0);
    full_read(BASE + 32'h18, 1'b0);

    // backpressure: both responses held for five cycles
    s_axi4lite_b_ready = 1'b0;
    s_axi4lite_r_ready = 1'b0;
    model_write(BASE + 32'h20, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    model_read(BASE + 32'h28);
    fork
      wr_fire(BASE + 32'h20, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0);
      send_ar(BASE + 32'h28);
    join
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_b_valid",  64'(s_axi4lite_b_valid),  64'd1);
      chk("bp_r_valid",  64'(s_axi4lite_r_valid),  64'd1);
      chk("bp_aw_ready", 64'(s_axi4lite_aw_ready), 64'd0);
      chk("bp_w_ready",  64'(s_axi4lite_w_ready),  64'd0);
      chk("bp_ar_ready", 64'(s_axi4lite_ar_ready), 64'd0);
    end
    @(posedge clk); #1;
    s_axi4lite_b_ready = 1'b1;
    s_axi4lite_r_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_b_done",   64'(s_axi4lite_b_valid),  64'd0);
    chk("bp_r_done",   64'(s_axi4lite_r_valid),  64'd0);
    chk("bp_b_queue",  64'(exp_b.size()),        64'd0);
    chk("bp_r_queue",  64'(exp_r.size()),        64'd0);
    chk("bp_ar_ready_back", 64'(s_axi4lite_ar_ready), 64'd1);
    @(posedge clk); #1;
    full_read(BASE + 32'h20, 1'b0);

    // same-word read and write in one cycle: read-first
    d = {$urandom, $urandom};
    model_read(BASE + 32'h10);
    model_write(BASE + 32'h10, d, 8'hFF);
    fork
      send_ar(BASE + 32'h10);
      send_aw(BASE + 32'h10);
      send_w(d, 8'hFF);
    join
    drain(1'b0);
    full_read(BASE + 32'h10, 1'b0);

    // one past the window: SLVERR with the check, alias to word 0 without
    full_write(BASE + WIN, 64'h5A5A_5A5A_A5A5_A5A5, 8'hFF, 1, 1'b0);
    full_read(BASE + WIN, 1'b0);
    full_read(BASE, 1'b0);

    // reset while the read is in its SRAM cycle
    send_ar(BASE + 32'h18);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_ar_ready", 64'(s_axi4lite_ar_ready), 64'd1);
    chk("midrst_aw_ready", 64'(s_axi4lite_aw_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_r_valid", 64'(s_axi4lite_r_valid), 64'd0);
    end
    @(posedge clk); #1;
    full_read(BASE + 32'h18, 1'b0);

    // randomized mix with random skew and random backpressure
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) a = BASE - 32'h40 + 32'($urandom_range(0, 319));
      else a = BASE + 32'($urandom_range(0, WORDS - 1) * 8) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) full_write(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 6) - 3, 1'b1);
      else full_read(a, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
